hazard_stall_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 5 +
 rtl/hazard_stall_ctrl_load_use_cmp.sv | 17 +
 rtl/hazard_stall_ctrl.sv | 100 ++++++++++
 tb/tb_hazard_stall_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;
    typedef enum logic [0:0] {RUN, MDU_WAIT} hz_state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_stall_ctrl_load_use_cmp.sv
// Combinational load-use detector: the EX load writes a register the ID instruction reads.
module load_use_cmp
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  idex_memread,
    input  logic [REG_ADDR_W-1:0] idex_rt,
    output logic                  lu
);
    // Loads into the zero register never create a dependency.
    assign lu = idex_memread && (idex_rt != REG_ADDR_W'(REG_ZERO)) &&
                ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard controller: load-use stall, branch flush, multi-cycle MDU stall and stall statistics.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MDU_LATENCY = 4,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic                   id_uses_rt,
    input  logic                   idex_memread,
    input  logic [REG_ADDR_W-1:0]  idex_rt,
    input  logic                   branch_taken,
    input  logic                   mdu_start,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   idex_write,
    output logic                   ifid_flush,
    output logic                   idex_bubble,
    output logic                   exmem_bubble,
    output logic                   mdu_busy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);
    localparam int CNT_W = $clog2(MDU_LATENCY);

    hz_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             lu;

    load_use_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_lu (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .lu           (lu)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        case (state)
            RUN: begin
                if (mdu_start) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_bubble = 1'b1;
                    state_nxt    = MDU_WAIT;
                    // The start cycle itself is the first stall cycle.
                    cnt_nxt      = CNT_W'(MDU_LATENCY - 2);
                end else if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (lu) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            MDU_WAIT: begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_bubble = 1'b1;
                if (cnt == '0) state_nxt = RUN;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            default: state_nxt = RUN;
        endcase
    end

    assign mdu_busy = (state == MDU_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (!pc_write && (stall_cycles != '1))
            stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl (MDU_LATENCY=4) plus a 3-bit-counter instance for saturation.
module tb_hazard_stall_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, idex_rt = '0;
    logic       id_uses_rt = 1'b0, idex_memread = 1'b0, branch_taken = 1'b0, mdu_start = 1'b0;

    logic        pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, exmem_bubble, mdu_busy;
    logic [31:0] stall_cycles;
    logic        s_pc_write, s_ifid_write, s_idex_write, s_ifid_flush, s_idex_bubble, s_exmem_bubble, s_mdu_busy;
    logic [2:0]  s_stall_cycles;

    typedef struct {
        logic [6:0] ctl;   // pc, ifid, idex, flush, idex_bub, exmem_bub, busy
        int         st;
        int         sat;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   drv_done = 1'b0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_ADDR_W(5), .MDU_LATENCY(4), .STALL_CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .branch_taken(branch_taken),
        .mdu_start(mdu_start), .pc_write(pc_write), .ifid_write(ifid_write),
        .idex_write(idex_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .exmem_bubble(exmem_bubble), .mdu_busy(mdu_busy), .stall_cycles(stall_cycles)
    );

    hazard_stall_ctrl #(.REG_ADDR_W(5), .MDU_LATENCY(4), .STALL_CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .branch_taken(branch_taken),
        .mdu_start(mdu_start), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
        .idex_write(s_idex_write), .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble),
        .exmem_bubble(s_exmem_bubble), .mdu_busy(s_mdu_busy), .stall_cycles(s_stall_cycles)
    );

    task automatic chk(input string tag, input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%0d expected=%0d", tag, name, act, exp);
        end
    endtask

    // One cycle of stimulus, applied just after the rising edge, with its expected response.
    task automatic cyc(input string tag, input logic r, input logic mr, input logic [4:0] xrt,
                       input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                       input logic br, input logic ms, input logic [6:0] ctl, input int st);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; idex_memread = mr; idex_rt = xrt; id_rs = rs; id_rt = rt;
        id_uses_rt = ur; branch_taken = br; mdu_start = ms;
        e.ctl = ctl; e.st = st; e.sat = (st > 7) ? 7 : st; e.tag = tag;
        q.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle; compare at the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.tag, "pc_write",     pc_write,     e.ctl[6]);
            chk(e.tag, "ifid_write",   ifid_write,   e.ctl[5]);
            chk(e.tag, "idex_write",   idex_write,   e.ctl[4]);
            chk(e.tag, "ifid_flush",   ifid_flush,   e.ctl[3]);
            chk(e.tag, "idex_bubble",  idex_bubble,  e.ctl[2]);
            chk(e.tag, "exmem_bubble", exmem_bubble, e.ctl[1]);
            chk(e.tag, "mdu_busy",     mdu_busy,     e.ctl[0]);
            chk(e.tag, "stall_cycles", stall_cycles, e.st);
            chk(e.tag, "sat_stall",    s_stall_cycles, e.sat);
        end
    end

    localparam logic [6:0] IDLE   = 7'b111_0000;
    localparam logic [6:0] LU     = 7'b001_0100;
    localparam logic [6:0] BR     = 7'b111_1100;
    localparam logic [6:0] MDU0   = 7'b000_0010;
    localparam logic [6:0] MDUW   = 7'b000_0011;

    initial begin
        //    tag          rst mr  xrt    rs     rt    ur br ms  expected  stall
        cyc("reset",       1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, IDLE, 0);
        cyc("idle",        0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, IDLE, 0);
        cyc("lu_rs",       0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, LU,   0);
        cyc("lu_after",    0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, IDLE, 1);
        cyc("rt_zero",     0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, IDLE, 1);
        cyc("rt_unused",   0, 1, 5'd7, 5'd3, 5'd7, 0, 0, 0, IDLE, 1);
        cyc("lu_rt",       0, 1, 5'd7, 5'd3, 5'd7, 1, 0, 0, LU,   1);
        cyc("lu_rt_after", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, IDLE, 2);
        cyc("br_vs_lu",    0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 0, BR,   2);
        cyc("br_after",    0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, IDLE, 2);
        // MDU op at cycle N; restart and hazards inside the wait must be ignored.
        cyc("mdu_n",       0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, MDU0, 2);
        cyc("mdu_n1",      0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, MDUW, 3);
        cyc("mdu_n2",      0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 0, MDUW, 4);
        cyc("mdu_n3",      0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, MDUW, 5);
        cyc("mdu_n4_lu",   0, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0, LU,   6);
        cyc("mdu_lu_done", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, IDLE, 7);
        // Reset lands in the middle of an MDU stall.
        cyc("mdu2_n",      0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, MDU0, 7);
        cyc("mdu2_n1",     0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, MDUW, 8);
        cyc("mdu2_rst",    1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, IDLE, 0);
        cyc("post_rst",    0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, IDLE, 0);
        // Continuous load-use stall drives the 3-bit counter into saturation.
        for (int k = 0; k < 10; k++)
            cyc("sat_lu",  0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0, LU,   k);
        cyc("sat_end",     0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, IDLE, 10);
        cyc("sat_hold",    0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, IDLE, 10);
        drv_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!(drv_done && q.size() == 0) && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        if (q.size() != 0 || !drv_done) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
